// File: rtl/key_event_ctrl.sv
// Key PIO interrupt service controller: programs the PIO interrupt mask, then on each
// irq reads and clears the edge-capture register and queues {seq, keys} events in a FIFO.
`timescale 1ns/1ps
module key_event_ctrl #(
  parameter logic [3:0] IRQ_MASK   = 4'hF,
  parameter int         FIFO_DEPTH = 8,
  parameter int         PTR_W      = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  output logic [1:0]     pio_address,
  output logic           pio_chipselect,
  output logic           pio_write_n,
  output logic [31:0]    pio_writedata,
  input  logic [31:0]    pio_readdata,
  input  logic           pio_irq,
  output logic           evt_valid,
  output logic [7:0]     evt_data,
  input  logic           evt_ready,
  output logic [PTR_W:0] evt_count,
  output logic           overflow,
  input  logic           overflow_clr,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    RD_REQ = 3'd2,
    RD_SMP = 3'd3,
    CLR    = 3'd4,
    PUSH   = 3'd5
  } state_t;

  localparam logic [1:0]       ADDR_MASK = 2'd2;
  localparam logic [1:0]       ADDR_EDGE = 2'd3;
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  state_t state, state_next;

  logic [1:0]  bus_addr_d;
  logic        bus_cs_d;
  logic        bus_wn_d;
  logic [31:0] bus_wdata_d;

  logic [3:0] keys_q;
  logic [3:0] seq_q;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    state_next = IDLE;
      IDLE:    if (pio_irq && enable) state_next = RD_REQ;
      RD_REQ:  state_next = RD_SMP;
      RD_SMP:  state_next = (pio_readdata[3:0] == 4'h0) ? IDLE : CLR;
      CLR:     state_next = PUSH;
      PUSH:    state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Bus outputs are registered so they are clean at reset; each access is loaded on
  // the edge that enters its state, and the mask write on the edge that leaves INIT.
  always_comb begin
    bus_addr_d  = 2'd0;
    bus_cs_d    = 1'b0;
    bus_wn_d    = 1'b1;
    bus_wdata_d = 32'h0;
    if (state == INIT) begin
      bus_addr_d  = ADDR_MASK;
      bus_cs_d    = 1'b1;
      bus_wn_d    = 1'b0;
      bus_wdata_d = {28'h0, IRQ_MASK};
    end else if (state_next == RD_REQ) begin
      bus_addr_d = ADDR_EDGE;
      bus_cs_d   = 1'b1;
    end else if (state_next == CLR) begin
      bus_addr_d  = ADDR_EDGE;
      bus_cs_d    = 1'b1;
      bus_wn_d    = 1'b0;
      bus_wdata_d = 32'hF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_address    <= 2'd0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= 32'h0;
    end else begin
      pio_address    <= bus_addr_d;
      pio_chipselect <= bus_cs_d;
      pio_write_n    <= bus_wn_d;
      pio_writedata  <= bus_wdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_q <= 4'h0;
      seq_q  <= 4'h0;
    end else begin
      if (state == RD_SMP) keys_q <= pio_readdata[3:0];
      if (state == PUSH)   seq_q  <= seq_q + 4'd1;
    end
  end

  // Event handshake: the head entry transfers on any edge where evt_valid && evt_ready;
  // evt_valid never depends on evt_ready, and evt_ready while empty has no effect.
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop, full, push_ok;

  assign push    = (state == PUSH);
  assign pop     = evt_valid && evt_ready;
  assign full    = (evt_count == DEPTH_C);
  assign push_ok = push && (!full || pop);

  assign evt_valid = (evt_count != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {seq_q, keys_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   evt_count <= evt_count + CNT_ONE;
        2'b01:   evt_count <= evt_count - CNT_ONE;
        default: evt_count <= evt_count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (overflow_clr)    overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with a behavioural key PIO (mask + edge-capture).
`timescale 1ns/1ps
module tb_key_event_ctrl;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_RD_REQ = 3'd2;
  localparam logic [2:0] S_RD_SMP = 3'd3;
  localparam logic [2:0] S_CLR    = 3'd4;
  localparam logic [2:0] S_PUSH   = 3'd5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        evt_valid;
  logic [7:0]  evt_data;
  logic        evt_ready;
  logic [3:0]  evt_count;
  logic        overflow;
  logic        overflow_clr;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // clock/reset block
  always #5 clk = ~clk;

  key_event_ctrl #(.IRQ_MASK(4'hF), .FIFO_DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_count(evt_count), .overflow(overflow), .overflow_clr(overflow_clr),
    .state_dbg(state_dbg)
  );

  // Key PIO model: registered readdata, mask at addr 2, edge-capture at addr 3
  // (write-1-to-clear), level irq = any captured bit under the mask.
  logic [3:0] edge_cap, mask_r, inject;
  logic       spurious;
  int         clr_writes;

  assign pio_irq = (|(edge_cap & mask_r)) | spurious;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap     <= 4'h0;
      mask_r       <= 4'h0;
      pio_readdata <= 32'h0;
      clr_writes   <= 0;
    end else begin
      if (pio_chipselect && pio_address == 2'd3) pio_readdata <= {28'h0, edge_cap};
      else if (pio_chipselect && pio_address == 2'd2) pio_readdata <= {28'h0, mask_r};
      else pio_readdata <= 32'h0;
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask_r <= pio_writedata[3:0];
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) begin
        edge_cap   <= (edge_cap & ~pio_writedata[3:0]) | inject;
        clr_writes <= clr_writes + 1;
      end else begin
        edge_cap <= edge_cap | inject;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    inject = k;
    step();
    inject = 4'h0;
  endtask

  task automatic run_event(input logic [3:0] k);
    press(k);
    repeat (5) step();
    check("event_back_idle", state_dbg, S_IDLE);
  endtask

  task automatic pop_expect(input logic [7:0] exp);
    check("pop_data", evt_data, exp);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_cs"},   pio_chipselect, 1'b0);
    check({tag, "_wn"},   pio_write_n,    1'b1);
    check({tag, "_addr"}, pio_address,    2'd0);
    check({tag, "_wd"},   pio_writedata,  32'h0);
  endtask

  task automatic check_mask_write(input string tag);
    check({tag, "_addr"}, pio_address,    2'd2);
    check({tag, "_cs"},   pio_chipselect, 1'b1);
    check({tag, "_wn"},   pio_write_n,    1'b0);
    check({tag, "_wd"},   pio_writedata,  32'h0000000F);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int cw;
    reset_n = 1'b0; enable = 1'b1; evt_ready = 1'b0; overflow_clr = 1'b0;
    inject = 4'h0; spurious = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_dbg, S_INIT);
    check_idle_bus("rst_bus");
    check("rst_valid", evt_valid, 1'b0);
    check("rst_count", evt_count, 4'd0);
    check("rst_data", evt_data, 8'h00);
    check("rst_ovf", overflow, 1'b0);

    // mask write on first cycle after release, then idle bus
    reset_n = 1'b1;
    step();
    check_mask_write("init");
    check("init_state", state_dbg, S_IDLE);
    step();
    check_idle_bus("post_init");

    // single event keys=0100; evt_ready held through PUSH on empty FIFO (no fall-through)
    press(4'b0100);
    step();
    check("ev1_state_rdreq", state_dbg, S_RD_REQ);
    check("ev1_rd_addr", pio_address, 2'd3);
    check("ev1_rd_cs", pio_chipselect, 1'b1);
    check("ev1_rd_wn", pio_write_n, 1'b1);
    step();
    check("ev1_state_rdsmp", state_dbg, S_RD_SMP);
    check("ev1_smp_cs", pio_chipselect, 1'b0);
    step();
    check("ev1_state_clr", state_dbg, S_CLR);
    check("ev1_clr_addr", pio_address, 2'd3);
    check("ev1_clr_wn", pio_write_n, 1'b0);
    check("ev1_clr_wd", pio_writedata, 32'hF);
    check("ev1_valid_early", evt_valid, 1'b0);
    step();
    check("ev1_state_push", state_dbg, S_PUSH);
    check("ev1_valid_push", evt_valid, 1'b0);
    evt_ready = 1'b1;
    step();
    check("ev1_state_idle", state_dbg, S_IDLE);
    check("ev1_valid", evt_valid, 1'b1);
    check("ev1_data", evt_data, 8'h04);
    check("ev1_count", evt_count, 4'd1);
    check("ev1_irq_cleared", pio_irq, 1'b0);
    step();
    evt_ready = 1'b0;
    check("ev1_popped_count", evt_count, 4'd0);
    check("ev1_popped_valid", evt_valid, 1'b0);

    // reset mid-sequence discards state and redoes the mask write
    press(4'b0001);
    step();
    step();
    check("rst2_pre_state", state_dbg, S_RD_SMP);
    reset_n = 1'b0;
    #1;
    check("rst2_state", state_dbg, S_INIT);
    check_idle_bus("rst2_bus");
    step();
    reset_n = 1'b1;
    step();
    check_mask_write("rst2_init");
    step();
    check("rst2_count", evt_count, 4'd0);

    // spurious irq with empty edge-capture: read, no clear, no push
    cw = clr_writes;
    spurious = 1'b1;
    step();
    spurious = 1'b0;
    check("spur_rdreq", state_dbg, S_RD_REQ);
    step();
    check("spur_rdsmp", state_dbg, S_RD_SMP);
    step();
    check("spur_idle", state_dbg, S_IDLE);
    check_idle_bus("spur_bus");
    step();
    check("spur_still_idle", state_dbg, S_IDLE);
    check("spur_no_clr", clr_writes, cw);
    check("spur_count", evt_count, 4'd0);

    // ten events into an 8-deep FIFO with no consumer
    for (int i = 0; i < 10; i++) run_event(4'h1);
    check("full_count", evt_count, 4'd8);
    check("full_ovf", overflow, 1'b1);
    check("full_head", evt_data, 8'h01);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // full FIFO: push coincides with pop; seq 10 is accepted at the tail
    press(4'h1);
    repeat (4) step();
    check("fullpp_state_push", state_dbg, S_PUSH);
    check("fullpp_popped_head", evt_data, 8'h01);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("fullpp_count", evt_count, 4'd8);
    check("fullpp_ovf", overflow, 1'b0);
    check("fullpp_head", evt_data, 8'h11);

    // drain: seq 1..7 then seq 10
    for (int i = 1; i < 8; i++) begin
      logic [3:0] s;
      s = 4'(i);
      pop_expect({s, 4'h1});
    end
    pop_expect(8'hA1);
    check("drain_count", evt_count, 4'd0);
    check("drain_valid", evt_valid, 1'b0);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("empty_pop_count", evt_count, 4'd0);

    // enable dropped in RD_SMP: sequence completes, later irq waits for enable
    press(4'b0010);
    step();
    step();
    check("en_rdsmp", state_dbg, S_RD_SMP);
    enable = 1'b0;
    repeat (3) step();
    check("en_done_idle", state_dbg, S_IDLE);
    check("en_count1", evt_count, 4'd1);
    check("en_data1", evt_data, 8'hB2);
    press(4'b1000);
    repeat (4) step();
    check("en_hold_idle", state_dbg, S_IDLE);
    check("en_hold_cs", pio_chipselect, 1'b0);
    check("en_hold_count", evt_count, 4'd1);
    enable = 1'b1;
    repeat (5) step();
    check("en_resume_idle", state_dbg, S_IDLE);
    check("en_count2", evt_count, 4'd2);
    pop_expect(8'hB2);
    pop_expect(8'hC8);
    check("en_final_count", evt_count, 4'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
